vector_logic_pipe: RTL and testbench

Parametrised, registered successor to the team's 3-bit vector gate block. Applies a selectable bitwise operation to two W-bit vectors over a valid/ready stream, with one output register stage. Adds packet-accumulate modes that fold a multi-beat stream into one result. Sits between a vector producer and a downstream consumer that can apply backpressure.

---
 rtl/vector_logic_pipe.sv | 146 ++++++++++++++
 tb/tb_vector_logic_pipe.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_logic_pipe.sv
// Registered bitwise-logic stage on a valid/ready stream, with packet-accumulate
// modes (ACC_OR / ACC_XOR) that fold a multi-beat packet into a single result.
module vector_logic_pipe #(
    parameter int W     = 3,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [2:0]       op,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_vec,
    output logic             out_logical,
    output logic [2*W-1:0]   out_not,
    output logic [CNT_W-1:0] out_beats,
    output logic             out_err
);

    typedef enum logic {IDLE, ACC} state_t;

    localparam logic [2:0]       OP_OR     = 3'b000;
    localparam logic [2:0]       OP_AND    = 3'b001;
    localparam logic [2:0]       OP_XOR    = 3'b010;
    localparam logic [2:0]       OP_NOR    = 3'b011;
    localparam logic [2:0]       OP_ACC_OR = 3'b100;
    localparam logic [2:0]       OP_ACC_XR = 3'b101;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    function automatic logic [W-1:0] apply_op(input logic [2:0] o,
                                              input logic [W-1:0] x,
                                              input logic [W-1:0] y);
        case (o)
            OP_OR, OP_ACC_OR:  return x | y;
            OP_AND:            return x & y;
            OP_XOR, OP_ACC_XR: return x ^ y;
            OP_NOR:            return ~(x | y);
            default:           return '0;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_ONE;
    endfunction

    state_t           state, state_d;
    logic [W-1:0]     acc, acc_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [2:0]       op_q, op_d;

    logic             accept, is_acc_op, load, res_err;
    logic [W-1:0]     beat_vec, fold_vec, res_vec;
    logic [CNT_W-1:0] res_beats;

    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign is_acc_op = (op == OP_ACC_OR) || (op == OP_ACC_XR);
    // Mid-packet, the op latched on the first beat governs every later beat.
    assign beat_vec  = apply_op((state == ACC) ? op_q : op, a, b);
    assign fold_vec  = apply_op(op_q, acc, beat_vec);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        state_d   = state;
        acc_d     = acc;
        cnt_d     = cnt;
        op_d      = op_q;
        load      = 1'b0;
        res_vec   = '0;
        res_beats = '0;
        res_err   = 1'b0;
        if (accept) begin
            case (state)
                IDLE: begin
                    if (is_acc_op && !in_last) begin
                        acc_d   = beat_vec;
                        op_d    = op;
                        cnt_d   = CNT_ONE;
                        state_d = ACC;
                    end else begin
                        load      = 1'b1;
                        res_vec   = beat_vec;
                        res_beats = CNT_ONE;
                        res_err   = (op[2:1] == 2'b11);
                    end
                end
                ACC: begin
                    if (in_last) begin
                        load      = 1'b1;
                        res_vec   = fold_vec;
                        res_beats = sat_inc(cnt);
                        acc_d     = '0;
                        cnt_d     = '0;
                        state_d   = IDLE;
                    end else begin
                        acc_d = fold_vec;
                        cnt_d = sat_inc(cnt);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            op_q  <= OP_OR;
        end else begin
            state <= state_d;
            acc   <= acc_d;
            cnt   <= cnt_d;
            op_q  <= op_d;
        end
    end

    // Output register only advances when the slot is free or draining; otherwise it holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_vec     <= '0;
            out_logical <= 1'b0;
            out_not     <= '0;
            out_beats   <= '0;
            out_err     <= 1'b0;
        end else if (in_ready) begin
            out_valid <= load;
            if (load) begin
                out_vec     <= res_vec;
                out_logical <= |res_vec;
                out_not     <= {~b, ~a};
                out_beats   <= res_beats;
                out_err     <= res_err;
            end
        end
    end

endmodule

// File: tb/tb_vector_logic_pipe.sv
// Scoreboard bench for vector_logic_pipe: a packet-level reference model pushes
// expected results; a negedge monitor pops and compares on every output transfer.
module tb_vector_logic_pipe;

    localparam int W       = 3;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk, reset;
    logic             in_valid, in_ready, in_last;
    logic [W-1:0]     in_a, in_b;
    logic [2:0]       in_op;
    logic             out_valid, out_ready, out_logical, out_err;
    logic [W-1:0]     out_vec;
    logic [2*W-1:0]   out_not;
    logic [CNT_W-1:0] out_beats;

    vector_logic_pipe #(.W(W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(in_a), .b(in_b), .op(in_op), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_vec(out_vec), .out_logical(out_logical), .out_not(out_not),
        .out_beats(out_beats), .out_err(out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]     vec;
        logic [2*W-1:0]   nt;
        logic [CNT_W-1:0] beats;
        logic             err;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   rand_ready = 0;

    logic [W-1:0] pkt_a[32];
    logic [W-1:0] pkt_b[32];
    logic [2:0]   pkt_op[32];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Monitor: compare each transfer against the scoreboard and check stall stability.
    exp_t mon_e, held;
    bit   stall_prev = 0;
    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", 64'(out_valid), 64'(1));
                check("hold_data", 64'({out_vec, out_not, out_beats, out_err}), 64'(held));
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    timeout("unexpected_output");
                end else begin
                    mon_e = sb_q.pop_front();
                    check("out_vec", 64'(out_vec), 64'(mon_e.vec));
                    check("out_logical", 64'(out_logical), 64'(|mon_e.vec));
                    check("out_not", 64'(out_not), 64'(mon_e.nt));
                    check("out_beats", 64'(out_beats), 64'(mon_e.beats));
                    check("out_err", 64'(out_err), 64'(mon_e.err));
                end
            end
            stall_prev = out_valid && !out_ready;
            held = {out_vec, out_not, out_beats, out_err};
        end
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Called at posedge+1; returns at posedge+1 right after the beat is accepted.
    task automatic send_beat(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [2:0] o, input logic last);
        int cyc = 0;
        in_valid = 1'b1;
        in_a = a; in_b = b; in_op = o; in_last = last;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            cyc++;
            if (cyc >= 200) begin
                timeout("in_ready_wait");
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a = W'($urandom); in_b = W'($urandom);
        in_op = 3'($urandom); in_last = 1'($urandom);
    endtask

    function automatic logic [W-1:0] ref_direct(input logic [2:0] o,
                                                input logic [W-1:0] a, input logic [W-1:0] b);
        case (o)
            3'd0: return a | b;
            3'd1: return a & b;
            3'd2: return a ^ b;
            3'd3: return ~(a | b);
            3'd4: return a | b;
            3'd5: return a ^ b;
            default: return '0;
        endcase
    endfunction

    // Packet model: OR/XOR reduction over every operand of the packet.
    task automatic run_packet(input logic [2:0] o, input int n, input bit quiet);
        exp_t e;
        logic [W-1:0] r = '0;
        if (o == 3'd4) begin
            for (int i = 0; i < n; i++) r = r | pkt_a[i] | pkt_b[i];
        end else if (o == 3'd5) begin
            for (int i = 0; i < n; i++) r = r ^ pkt_a[i] ^ pkt_b[i];
        end else begin
            r = ref_direct(o, pkt_a[0], pkt_b[0]);
        end
        e.vec   = r;
        e.nt    = {~pkt_b[n-1], ~pkt_a[n-1]};
        e.beats = CNT_W'((n > CNT_MAX) ? CNT_MAX : n);
        e.err   = (o >= 3'd6);
        sb_q.push_back(e);
        for (int i = 0; i < n; i++) begin
            logic last;
            if (o < 3'd4 || o > 3'd5) last = 1'($urandom);
            else last = (i == n - 1);
            send_beat(pkt_a[i], pkt_b[i], (i == 0) ? o : pkt_op[i], last);
            if (quiet && i < n - 1) check("acc_no_output", 64'(out_valid), 64'(0));
        end
    endtask

    task automatic drain();
        int cyc = 0;
        while (sb_q.size() != 0 && cyc < 1000) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        if (sb_q.size() != 0) timeout("drain");
    endtask

    task automatic single(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        pkt_a[0] = a; pkt_b[0] = b;
        run_packet(o, 1, 0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_op = '0; in_last = 1'b0;
        #2;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_state", 64'({out_vec, out_logical, out_not, out_beats, out_err}), 64'(0));
        #20;
        @(negedge clk);
        reset = 1'b0;
        check("rst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // Direct ops
        single(3'b000, 3'b101, 3'b010);
        single(3'b001, 3'b100, 3'b011);
        single(3'b011, 3'b000, 3'b000);
        single(3'b010, 3'b110, 3'b011);
        drain();

        // ACC_XOR, 3 beats, op input changed to OR on beat 2
        pkt_a[0] = 3'b001; pkt_b[0] = 3'b000;
        pkt_a[1] = 3'b010; pkt_b[1] = 3'b000; pkt_op[1] = 3'b000;
        pkt_a[2] = 3'b011; pkt_b[2] = 3'b000; pkt_op[2] = 3'b001;
        run_packet(3'b101, 3, 1);
        drain();

        // Backpressure: result stalls for 5 cycles while a new beat waits
        out_ready = 1'b0;
        single(3'b000, 3'b001, 3'b100);
        pkt_a[0] = 3'b111; pkt_b[0] = 3'b010;
        begin
            exp_t e2;
            e2.vec = 3'b010; e2.nt = {~3'b010, ~3'b111}; e2.beats = 1; e2.err = 0;
            sb_q.push_back(e2);
        end
        fork
            send_beat(3'b111, 3'b010, 3'b001, 1'b0);
            begin
                repeat (5) begin
                    @(negedge clk);
                    check("stall_in_ready", 64'(in_ready), 64'(0));
                    check("stall_out_valid", 64'(out_valid), 64'(1));
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        check("same_cycle_accept_valid", 64'(out_valid), 64'(1));
        check("same_cycle_accept_q", 64'(sb_q.size()), 64'(1));
        drain();

        // Beat-count saturation with an 18-beat ACC_OR packet
        for (int i = 0; i < 18; i++) begin
            pkt_a[i] = W'($urandom); pkt_b[i] = W'($urandom); pkt_op[i] = 3'($urandom);
        end
        run_packet(3'b100, 18, 1);
        drain();

        // Async reset mid-packet discards the partial accumulation
        send_beat(3'b110, 3'b000, 3'b100, 1'b0);
        send_beat(3'b010, 3'b001, 3'b000, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        single(3'b100, 3'b001, 3'b000);
        single(3'b110, 3'b101, 3'b011);
        single(3'b111, 3'b010, 3'b010);
        drain();

        // Randomized packets under random backpressure
        rand_ready = 1;
        for (int p = 0; p < 60; p++) begin
            logic [2:0] o = 3'($urandom_range(0, 7));
            int n = 1;
            if (o == 3'd4 || o == 3'd5) n = $urandom_range(1, (p % 6 == 0) ? 20 : 5);
            for (int i = 0; i < n; i++) begin
                pkt_a[i] = W'($urandom); pkt_b[i] = W'($urandom); pkt_op[i] = 3'($urandom);
            end
            run_packet(o, n, 0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        drain();
        rand_ready = 0;
        check("final_queue_empty", 64'(sb_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
